quant_ctrl: RTL and testbench

- Sequencer for the shared int8 requantizer datapath: accepts a channel-major stream of 32-bit signed accumulators and feeds them to the requantizer, one per cycle.
- Drives per-channel mult/shift/zero_point from an internal table, draining the pipeline on every channel switch.
- Buffers returning bytes in a credit-protected FIFO and packs 4 bytes per 32-bit output word with ready/valid backpressure.
- Sits between the accumulator buffer and the activation write-back.

---
 rtl/quant_ctrl_pkg.sv | 23 ++
 rtl/quant_byte_fifo.sv | 48 ++++
 rtl/quant_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_quant_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_ctrl_pkg.sv
// rtl/quant_ctrl_pkg.sv - shared types and widths for the requantizer sequencer
package quant_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        FLUSH
    } state_t;

    localparam int MULT_W  = 15;
    localparam int SHIFT_W = 8;
    localparam int ZP_W    = 8;
    localparam int ACC_W   = 32;

    typedef struct packed {
        logic [MULT_W-1:0]  mult;
        logic [SHIFT_W-1:0] shift;
        logic [ZP_W-1:0]    zp;
    } qparam_t;

endpackage

// File: rtl/quant_byte_fifo.sv
// rtl/quant_byte_fifo.sv - synchronous byte FIFO with occupancy count and show-ahead read
module quant_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     sclk,
    input  logic                     s_rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // Upstream credit accounting must make this unreachable.
    a_no_overflow: assert property (@(posedge sclk) disable iff (s_rst)
        !(wr_en && count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/quant_ctrl.sv
// rtl/quant_ctrl.sv - channel sequencer, credit-protected byte buffer and 4-byte packer for the requantizer
module quant_ctrl
    import quant_ctrl_pkg::*;
#(
    parameter int CH_W       = 6,
    parameter int PIX_W      = 12,
    parameter int Q_LAT      = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                sclk,
    input  logic                s_rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_addr,
    input  logic [MULT_W-1:0]   cfg_mult,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic [ZP_W-1:0]     cfg_zp,
    input  logic                start,
    input  logic [CH_W:0]       num_ch,
    input  logic [PIX_W-1:0]    num_pix,
    input  logic                acc_valid,
    output logic                acc_ready,
    input  logic [ACC_W-1:0]    acc_data,
    output logic [ACC_W-1:0]    q_data_in,
    output logic [MULT_W-1:0]   q_mult,
    output logic [SHIFT_W-1:0]  q_shift,
    output logic [ZP_W-1:0]     q_zp,
    input  logic [7:0]          q_data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic [3:0]          out_keep,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = FCNT_W + 1;

    state_t            state, state_nxt;
    qparam_t           tbl [2**CH_W];
    logic [CH_W:0]     num_ch_r;
    logic [PIX_W-1:0]  num_pix_r;
    logic [CH_W-1:0]   ch;
    logic [PIX_W-1:0]  pix;
    logic [Q_LAT-1:0]  vld_sr;
    logic [CRED_W-1:0] inflight;
    logic [FCNT_W-1:0] fifo_count;
    logic [7:0]        fifo_rd_data;
    logic              fifo_pop;
    logic              accept, last_pix, last_ch;

    // Packer state: bytes of the word being assembled plus position within the job
    logic [31:0]       asm_data;
    logic [1:0]        asm_cnt;
    logic [PIX_W-1:0]  pk_pix;
    logic [CH_W-1:0]   pk_ch;
    logic              pk_end_ch, pk_last_ch, word_close, out_free;
    logic [31:0]       packed_word;
    logic [3:0]        keep_new;

    always_ff @(posedge sclk) begin
        if (cfg_we) begin
            tbl[cfg_addr] <= '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp};
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < Q_LAT; i++) begin
            inflight = inflight + CRED_W'(vld_sr[i]);
        end
    end

    assign acc_ready = (state == RUN) && ((CRED_W'(fifo_count) + inflight) < CRED_W'(FIFO_DEPTH));
    assign accept    = acc_valid && acc_ready;
    assign last_pix  = (pix == num_pix_r - PIX_W'(1));
    assign last_ch   = ({1'b0, ch} == num_ch_r - (CH_W+1)'(1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (accept && last_pix) state_nxt = DRAIN;
            DRAIN:   if (inflight == '0) state_nxt = last_ch ? FLUSH : LOAD;
            FLUSH:   if (out_valid && out_ready && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            num_ch_r  <= '0;
            num_pix_r <= '0;
            ch        <= '0;
            pix       <= '0;
            vld_sr    <= '0;
            q_data_in <= '0;
            q_mult    <= '0;
            q_shift   <= '0;
            q_zp      <= '0;
            done      <= 1'b0;
        end else begin
            done   <= (state == FLUSH) && out_valid && out_ready && out_last;
            vld_sr <= (vld_sr << 1) | Q_LAT'(accept);
            if (state == IDLE && start) begin
                num_ch_r  <= num_ch;
                num_pix_r <= num_pix;
                ch        <= '0;
                pix       <= '0;
            end
            if (state == LOAD) begin
                q_mult  <= tbl[ch].mult;
                q_shift <= tbl[ch].shift;
                q_zp    <= tbl[ch].zp;
            end
            if (accept) begin
                q_data_in <= acc_data;
                pix       <= pix + PIX_W'(1);
            end
            if (state == DRAIN && inflight == '0 && !last_ch) begin
                ch  <= ch + CH_W'(1);
                pix <= '0;
            end
        end
    end

    quant_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sclk    (sclk),
        .s_rst   (s_rst),
        .wr_en   (vld_sr[Q_LAT-1]),
        .wr_data (q_data_out),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    // A byte that completes a word may only be popped once the output register can take it
    assign pk_end_ch   = (pk_pix == num_pix_r - PIX_W'(1));
    assign pk_last_ch  = ({1'b0, pk_ch} == num_ch_r - (CH_W+1)'(1));
    assign word_close  = (asm_cnt == 2'd3) || pk_end_ch;
    assign out_free    = !out_valid || out_ready;
    assign fifo_pop    = (fifo_count != '0) && (!word_close || out_free);
    assign packed_word = asm_data | (32'(fifo_rd_data) << {asm_cnt, 3'b000});
    assign keep_new    = (4'b0010 << asm_cnt) - 4'd1;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            asm_data  <= '0;
            asm_cnt   <= '0;
            pk_pix    <= '0;
            pk_ch     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (fifo_pop) begin
                if (word_close) begin
                    out_data  <= packed_word;
                    out_keep  <= keep_new;
                    out_last  <= pk_end_ch && pk_last_ch;
                    out_valid <= 1'b1;
                    asm_data  <= '0;
                    asm_cnt   <= '0;
                end else begin
                    asm_data <= packed_word;
                    asm_cnt  <= asm_cnt + 2'd1;
                end
                if (pk_end_ch) begin
                    pk_pix <= '0;
                    pk_ch  <= pk_ch + CH_W'(1);
                end else begin
                    pk_pix <= pk_pix + PIX_W'(1);
                end
            end
            if (state == IDLE) begin
                pk_pix <= '0;
                pk_ch  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_quant_ctrl.sv
// tb/tb_quant_ctrl.sv - scoreboard bench for quant_ctrl with a behavioural requantizer
module tb_quant_ctrl;

    localparam int Q_LAT = 3;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [14:0] cfg_mult = '0;
    logic [7:0]  cfg_shift = '0;
    logic [7:0]  cfg_zp = '0;
    logic        start = 1'b0;
    logic [6:0]  num_ch = '0;
    logic [11:0] num_pix = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    logic [31:0] acc_data = '0;
    logic [31:0] q_data_in;
    logic [14:0] q_mult;
    logic [7:0]  q_shift;
    logic [7:0]  q_zp;
    logic [7:0]  q_data_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        busy;
    logic        done;

    int          n_cmp = 0;
    int          n_bad = 0;
    word_t       sb[$];
    word_t       exp_w;
    logic [31:0] acc_q[$];
    int          fed_cnt = 0;
    int          gap = 0;
    bit          abort = 1'b0;
    bit          done_due = 1'b0;
    logic [7:0]  rq1, rq2;

    quant_ctrl #(.CH_W(6), .PIX_W(12), .Q_LAT(Q_LAT), .FIFO_DEPTH(16)) dut (
        .sclk(sclk), .s_rst(s_rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .start(start), .num_ch(num_ch), .num_pix(num_pix),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .q_data_in(q_data_in), .q_mult(q_mult), .q_shift(q_shift), .q_zp(q_zp), .q_data_out(q_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 sclk = ~sclk;

    function automatic logic [7:0] requant(logic [31:0] x, logic [14:0] m, logic [7:0] s, logic [7:0] z);
        longint p, r;
        p = longint'($signed(x)) * longint'({1'b0, m});
        r = (p >>> (15 + s)) + ((p >>> (14 + s)) & 64'sd1) + longint'(z);
        return r[7:0];
    endfunction

    // Requantizer stand-in: q_data_out is valid Q_LAT cycles after the sample was accepted
    always @(posedge sclk) begin
        rq1 <= requant(q_data_in, q_mult, q_shift, q_zp);
        rq2 <= rq1;
    end
    assign q_data_out = rq2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sclk) begin
        if (done || done_due) chk("done_pulse", 64'(done), 64'(done_due));
        done_due = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %08h keep %h last %b, none expected", out_data, out_keep, out_last);
            end else begin
                exp_w = sb.pop_front();
                chk("word{data,keep,last}", 64'({out_data, out_keep, out_last}), 64'(exp_w));
            end
            done_due = out_last;
        end
    end

    task automatic cfg_wr(input logic [5:0] a, input logic [14:0] m, input logic [7:0] s, input logic [7:0] z);
        @(posedge sclk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_mult = m; cfg_shift = s; cfg_zp = z;
        @(posedge sclk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_job(input logic [6:0] nch, input logic [11:0] npix);
        @(posedge sclk); #1;
        num_ch = nch; num_pix = npix; start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n);
        int   cyc;
        logic rdy;
        fed_cnt = 0; gap = 0; cyc = 0;
        acc_valid = 1'b1; acc_data = acc_q[0];
        while (fed_cnt < n && !abort && cyc < 2000) begin
            @(negedge sclk);
            rdy = acc_ready;
            if (!rdy && fed_cnt > 0) gap++;
            @(posedge sclk); #1;
            if (rdy) begin
                fed_cnt++;
                if (fed_cnt < n) acc_data = acc_q[fed_cnt];
            end
            cyc++;
        end
        acc_valid = 1'b0;
        if (fed_cnt < n && !abort) chk("feed_timeout", 64'(fed_cnt), 64'(n));
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 400) begin
            @(negedge sclk);
            c++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_acc_ready"}, 64'(acc_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_q_bus"}, 64'({q_data_in, q_mult, q_shift, q_zp}), 64'd0);
        chk({tag, "_out_bus"}, 64'({out_data, out_keep, out_last}), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        check_idle_outputs("reset");
        s_rst = 1'b0;

        cfg_wr(6'd0, 15'd16384, 8'd0, 8'd10);
        cfg_wr(6'd1, 15'd32767, 8'd0, 8'd0);

        // Single channel, one full word
        acc_q = '{32'd100, 32'd101, 32'd100, 32'd101};
        sb.push_back('{32'h3D3C3D3C, 4'hF, 1'b1});
        start_job(7'd1, 12'd4);
        @(negedge sclk);
        chk("busy_after_start", 64'(busy), 64'd1);
        feed(4);
        wait_done();

        // Partial closing word
        acc_q = '{32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100};
        sb.push_back('{32'h3C3C3C3C, 4'hF, 1'b0});
        sb.push_back('{32'h00003C3C, 4'h3, 1'b1});
        start_job(7'd1, 12'd6);
        feed(6);
        wait_done();

        // Channel switch with pipeline drain gap
        acc_q.delete();
        for (int i = 0; i < 8; i++) acc_q.push_back(32'd200);
        sb.push_back('{32'h6E6E6E6E, 4'hF, 1'b0});
        sb.push_back('{32'hC8C8C8C8, 4'hF, 1'b1});
        start_job(7'd2, 12'd4);
        feed(8);
        chk("channel_gap", 64'(gap), 64'(Q_LAT + 2));
        wait_done();

        // Output backpressure throttles issue through credit
        acc_q.delete();
        for (int k = 0; k < 32; k++) acc_q.push_back(32'(2 * k));
        for (int w = 0; w < 8; w++)
            sb.push_back('{{8'(4*w+13), 8'(4*w+12), 8'(4*w+11), 8'(4*w+10)}, 4'hF, (w == 7)});
        out_ready = 1'b0;
        start_job(7'd1, 12'd32);
        fed_cnt = 0;
        fork
            feed(32);
            begin
                repeat (40) @(posedge sclk);
                @(negedge sclk);
                chk("bp_acc_ready_low", 64'(acc_ready), 64'd0);
                chk("bp_accepted_in_credit_window", 64'(fed_cnt >= 16 && fed_cnt <= 23), 64'd1);
                out_ready = 1'b1;
            end
        join
        wait_done();

        // Reset during sample 3 of 8 aborts the job
        acc_q.delete();
        for (int i = 0; i < 8; i++) acc_q.push_back(32'd100);
        start_job(7'd1, 12'd8);
        fed_cnt = 0;
        fork
            feed(8);
            begin
                int c = 0;
                while (fed_cnt < 2 && c < 100) begin
                    @(negedge sclk);
                    c++;
                end
                chk("reset_point_reached", 64'(fed_cnt), 64'd2);
                s_rst = 1'b1;
                abort = 1'b1;
                @(posedge sclk);
                @(negedge sclk);
                check_idle_outputs("midrun_reset");
                s_rst = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (10) @(negedge sclk);
        chk("no_stray_words", 64'(sb.size()), 64'd0);
        acc_q = '{32'd100, 32'd101, 32'd100, 32'd101};
        sb.push_back('{32'h3D3C3D3C, 4'hF, 1'b1});
        start_job(7'd1, 12'd4);
        feed(4);
        wait_done();

        // Start while busy is ignored; ch1 rewritten while ch0 runs
        acc_q.delete();
        for (int i = 0; i < 8; i++) acc_q.push_back(32'd200);
        sb.push_back('{32'h6E6E6E6E, 4'hF, 1'b0});
        sb.push_back('{32'h37373737, 4'hF, 1'b1});
        start_job(7'd2, 12'd4);
        fed_cnt = 0;
        fork
            feed(8);
            begin
                int c = 0;
                while (fed_cnt < 1 && c < 100) begin
                    @(negedge sclk);
                    c++;
                end
                @(posedge sclk); #1;
                num_ch = 7'd1; num_pix = 12'd1; start = 1'b1;
                @(posedge sclk); #1;
                start = 1'b0;
                cfg_wr(6'd1, 15'd16384, 8'd1, 8'd5);
            end
        join
        wait_done();

        repeat (5) @(negedge sclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
